// File: rtl/brcomp_seq.sv
// Multi-cycle branch comparator: walks the operands CHUNK bits per cycle from the
// MSB end, stops at the first differing chunk and resolves less/equal/taken.
module brcomp_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             br_unsigned_i,
   input  logic [2:0]       funct3_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             br_less_o,
   output logic             br_equal_o,
   output logic             br_taken_o,
   output logic             busy_o
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   generate
      if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
         $error("brcomp_seq: CHUNK must be a positive divisor of WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, b_reg;
   logic [WIDTH-1:0]   a_in, b_in;
   logic [2:0]         funct3_reg;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               less_reg, less_next;
   logic               equal_reg, equal_next;
   logic               taken_reg, taken_next;
   logic               accept;
   logic [CHUNK-1:0]   a_chunks [NUM_CHUNKS];
   logic [CHUNK-1:0]   b_chunks [NUM_CHUNKS];
   logic [CHUNK-1:0]   a_cur, b_cur;

   generate
      for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
         assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
         assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   assign a_cur = a_chunks[idx_reg];
   assign b_cur = b_chunks[idx_reg];

   function automatic logic taken_of(input logic [2:0] f3, input logic lt, input logic eq);
      case (f3)
         3'b000:          return eq;
         3'b001:          return !eq;
         3'b100, 3'b110:  return lt;
         3'b101, 3'b111:  return !lt;
         default:         return 1'b0;
      endcase
   endfunction

   assign req_ready_o = (state_reg == IDLE) && !flush_i && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state_reg == DONE);
   assign busy_o      = (state_reg != IDLE);
   assign br_less_o   = less_reg;
   assign br_equal_o  = equal_reg;
   assign br_taken_o  = taken_reg;

   // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
   always_comb begin
      a_in = operand_a_i;
      b_in = operand_b_i;
      a_in[WIDTH-1] = operand_a_i[WIDTH-1] ^ !br_unsigned_i;
      b_in[WIDTH-1] = operand_b_i[WIDTH-1] ^ !br_unsigned_i;
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      less_next  = less_reg;
      equal_next = equal_reg;
      taken_next = taken_reg;
      unique case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = CMP;
               idx_next   = IDX_W'(NUM_CHUNKS - 1);
            end
         end
         CMP: begin
            if (a_cur != b_cur) begin
               less_next  = (a_cur < b_cur);
               equal_next = 1'b0;
               taken_next = taken_of(funct3_reg, a_cur < b_cur, 1'b0);
               state_next = DONE;
            end else if (idx_reg == '0) begin
               less_next  = 1'b0;
               equal_next = 1'b1;
               taken_next = taken_of(funct3_reg, 1'b0, 1'b1);
               state_next = DONE;
            end else begin
               idx_next = idx_reg - IDX_W'(1);
            end
         end
         DONE: begin
            if (rsp_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // A flush drops the operation and leaves the last published result untouched.
      if (flush_i) begin
         state_next = IDLE;
         less_next  = less_reg;
         equal_next = equal_reg;
         taken_next = taken_reg;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         less_reg  <= 1'b0;
         equal_reg <= 1'b0;
         taken_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         less_reg  <= less_next;
         equal_reg <= equal_next;
         taken_reg <= taken_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         a_reg      <= a_in;
         b_reg      <= b_in;
         funct3_reg <= funct3_i;
      end
   end

endmodule

// File: tb/tb_brcomp_seq.sv
// Bench for brcomp_seq: directed scenarios plus random operations checked against
// an arithmetic reference model of the branch comparison and its latency.
module tb_brcomp_seq;

   localparam int WIDTH      = 32;
   localparam int CHUNK      = 8;
   localparam int NUM_CHUNKS = WIDTH / CHUNK;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              flush_i = 1'b0;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic [WIDTH-1:0]  operand_a_i = '0;
   logic [WIDTH-1:0]  operand_b_i = '0;
   logic              br_unsigned_i = 1'b0;
   logic [2:0]        funct3_i = 3'b000;
   logic              rsp_valid_o;
   logic              rsp_ready_i = 1'b0;
   logic              br_less_o;
   logic              br_equal_o;
   logic              br_taken_o;
   logic              busy_o;

   int   checks = 0;
   int   errors = 0;
   logic exp_less = 1'b0;
   logic exp_equal = 1'b0;
   logic exp_taken = 1'b0;

   brcomp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .br_unsigned_i(br_unsigned_i), .funct3_i(funct3_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .br_less_o(br_less_o), .br_equal_o(br_equal_o), .br_taken_o(br_taken_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Chunks examined = chunks from the MSB end down to the one holding the highest differing bit.
   function automatic int model_chunks(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x;
      int p;
      x = a ^ b;
      p = -1;
      for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
      return (p < 0) ? NUM_CHUNKS : NUM_CHUNKS - p / CHUNK;
   endfunction

   function automatic logic model_taken(input logic [2:0] f3, input logic lt, input logic eq);
      case (f3)
         3'b000:          return eq;
         3'b001:          return !eq;
         3'b100, 3'b110:  return lt;
         3'b101, 3'b111:  return !lt;
         default:         return 1'b0;
      endcase
   endfunction

   task automatic set_expect(input logic [31:0] a, input logic [31:0] b, input logic uns,
                             input logic [2:0] f3);
      logic lt;
      lt = uns ? (a < b) : ($signed(a) < $signed(b));
      exp_less  = lt;
      exp_equal = (a == b);
      exp_taken = model_taken(f3, lt, a == b);
   endtask

   // Entered and left at posedge+1 with the DUT idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         input logic [2:0] f3, input int stall, input string tag);
      int   k;
      int   cyc;
      logic got;
      set_expect(a, b, uns, f3);
      k = model_chunks(a, b);
      operand_a_i = a; operand_b_i = b; br_unsigned_i = uns; funct3_i = f3;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      check({tag, ".req_ready_idle"}, 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      operand_a_i = $urandom; operand_b_i = $urandom;
      br_unsigned_i = 1'($urandom); funct3_i = 3'($urandom);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < NUM_CHUNKS + 4) begin
         @(negedge clk_i);
         cyc++;
         check({tag, ".busy"}, 32'(busy_o), 32'd1);
         got = rsp_valid_o;
      end
      check({tag, ".latency"}, 32'(cyc), 32'(1 + k));
      if (!got) begin
         flush_i = 1'b1;
         @(posedge clk_i); #1;
         flush_i = 1'b0;
         return;
      end
      check({tag, ".less"}, 32'(br_less_o), 32'(exp_less));
      check({tag, ".equal"}, 32'(br_equal_o), 32'(exp_equal));
      check({tag, ".taken"}, 32'(br_taken_o), 32'(exp_taken));
      check({tag, ".req_ready_done"}, 32'(req_ready_o), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk_i); #1;
         req_valid_i = 1'b1;
         @(negedge clk_i);
         check({tag, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
         check({tag, ".hold_less"}, 32'(br_less_o), 32'(exp_less));
         check({tag, ".hold_equal"}, 32'(br_equal_o), 32'(exp_equal));
         check({tag, ".hold_taken"}, 32'(br_taken_o), 32'(exp_taken));
         check({tag, ".hold_req_ready"}, 32'(req_ready_o), 32'd0);
         req_valid_i = 1'b0;
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      check({tag, ".after_hs_valid"}, 32'(rsp_valid_o), 32'd0);
      check({tag, ".after_hs_busy"}, 32'(busy_o), 32'd0);
      $display("op %s a=%h b=%h uns=%0d f3=%b -> less=%0d equal=%0d taken=%0d chunks=%0d stall=%0d",
               tag, a, b, uns, f3, exp_less, exp_equal, exp_taken, k, stall);
   endtask

   // Accept an operation, then kill it at t+3 with flush or reset.
   task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                           input logic use_rst, input string tag);
      operand_a_i = a; operand_b_i = b; br_unsigned_i = 1'b0; funct3_i = f3;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      check({tag, ".req_ready_idle"}, 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
      @(negedge clk_i);
      check({tag, ".req_ready_abort"}, 32'(req_ready_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      flush_i = 1'b0;
      check({tag, ".valid_t4"}, 32'(rsp_valid_o), 32'd0);
      check({tag, ".busy_t4"}, 32'(busy_o), 32'd0);
      check({tag, ".less_t4"}, 32'(br_less_o), use_rst ? 32'd0 : 32'(exp_less));
      check({tag, ".equal_t4"}, 32'(br_equal_o), use_rst ? 32'd0 : 32'(exp_equal));
      check({tag, ".taken_t4"}, 32'(br_taken_o), use_rst ? 32'd0 : 32'(exp_taken));
      @(negedge clk_i);
      check({tag, ".req_ready_t4"}, 32'(req_ready_o), 32'd1);
      for (int i = 0; i < NUM_CHUNKS + 2; i++) begin
         @(negedge clk_i);
         check({tag, ".no_rsp"}, 32'(rsp_valid_o), 32'd0);
      end
      @(posedge clk_i); #1;
      if (use_rst) begin
         exp_less = 1'b0; exp_equal = 1'b0; exp_taken = 1'b0;
      end
      $display("abort %s a=%h b=%h by %s at t+3", tag, a, b, use_rst ? "reset" : "flush");
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          mode;

      // Reset, with a request pending to show it is refused.
      req_valid_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("reset.req_ready", 32'(req_ready_o), 32'd0);
      check("reset.rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("reset.busy", 32'(busy_o), 32'd0);
      check("reset.less", 32'(br_less_o), 32'd0);
      check("reset.equal", 32'(br_equal_o), 32'd0);
      check("reset.taken", 32'(br_taken_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      check("reset.busy_after", 32'(busy_o), 32'd0);
      @(posedge clk_i); #1;

      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 0, "s1_signed_blt");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, 0, "s2_unsigned_bltu");
      run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 0, "s3_equal_beq");
      run_op(32'h1234_5600, 32'h1234_5601, 1'b1, 3'b111, 0, "s4_bgeu_lsb");
      run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 3, "s5_stall");
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b101, 0, "s5_back_to_back");
      run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 3'b010, 0, "f3_010_never");

      // Flush in the same cycle as a request: nothing is accepted.
      flush_i = 1'b1;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      check("flush_req.req_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      req_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("flush_req.busy", 32'(busy_o), 32'd0);
      end
      @(posedge clk_i); #1;

      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 0, "s6_pre_flush");
      abort_op(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0, "s6_flush");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 0, "s6_pre_reset");
      abort_op(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1, "s6_reset");

      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       rb = $urandom;
            1:       rb = ra;
            2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
            default: rb = {ra[31:16], 16'($urandom)};
         endcase
         run_op(ra, rb, 1'($urandom), 3'($urandom), $urandom_range(0, 2), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
